// File: rtl/quad_encoder_gen_pkg.sv
// Shared definitions for the quadrature transmitter: FSM encodings, AB phase
// patterns per direction and the timer width helper.
package quad_encoder_gen_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PH1   = 3'd1;
    localparam logic [2:0] ST_PH2   = 3'd2;
    localparam logic [2:0] ST_PH3   = 3'd3;
    localparam logic [2:0] ST_PH0   = 3'd4;
    localparam logic [2:0] ST_DWELL = 3'd5;

    // AB pairs, A in bit 1. CW lets A lead, CCW lets B lead; both end at detent 00.
    localparam logic [1:0] AB_CW_PH1  = 2'b10;
    localparam logic [1:0] AB_CW_PH2  = 2'b11;
    localparam logic [1:0] AB_CW_PH3  = 2'b01;
    localparam logic [1:0] AB_CCW_PH1 = 2'b01;
    localparam logic [1:0] AB_CCW_PH2 = 2'b11;
    localparam logic [1:0] AB_CCW_PH3 = 2'b10;
    localparam logic [1:0] AB_DETENT  = 2'b00;

    function automatic logic [1:0] phase_ab(input logic [2:0] st, input logic dir_cw);
        logic [1:0] ab;
        ab = AB_DETENT;
        case (st)
            ST_PH1:  ab = dir_cw ? AB_CW_PH1 : AB_CCW_PH1;
            ST_PH2:  ab = dir_cw ? AB_CW_PH2 : AB_CCW_PH2;
            ST_PH3:  ab = dir_cw ? AB_CW_PH3 : AB_CCW_PH3;
            default: ab = AB_DETENT;
        endcase
        return ab;
    endfunction

    function automatic int timer_width(input int phase_cyc, input int dwell_cyc);
        int m;
        m = (phase_cyc > dwell_cyc) ? phase_cyc : dwell_cyc;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/quad_encoder_gen_timer.sv
// Loadable down-counter used to hold each quadrature phase and the dwell gap.
// expired is high while the count sits at zero.
module phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature transmitter: emits ROT_A/ROT_B waveforms equivalent to a rotary
// encoder advancing a requested number of detents in the requested direction.
module quad_encoder_gen
    import quad_encoder_gen_pkg::*;
#(
    parameter int PHASE_CYC = 4,
    parameter int DWELL_CYC = 8,
    parameter int STEP_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              dir,
    input  logic [STEP_W-1:0] steps,
    output logic              ROT_A,
    output logic              ROT_B,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps_left
);

    localparam int TMR_W = timer_width(PHASE_CYC, DWELL_CYC);
    localparam logic [TMR_W-1:0] PH_LOAD = TMR_W'(PHASE_CYC - 1);
    localparam logic [TMR_W-1:0] DW_LOAD = TMR_W'((DWELL_CYC > 0) ? DWELL_CYC - 1 : 0);

    logic [2:0]        state_q, state_d;
    logic              dir_q, dir_d;
    logic [STEP_W-1:0] steps_left_q, steps_left_d;
    logic              rot_a_q, rot_a_d;
    logic              rot_b_q, rot_b_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              timer_load;
    logic [TMR_W-1:0]  timer_value;
    logic              timer_expired;

    phase_timer #(.W(TMR_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .value   (timer_value),
        .expired (timer_expired)
    );

    // Handshake: start is looked at only in IDLE (busy=0). An accepted start
    // raises busy on the next edge; busy drops on the same edge done pulses,
    // so a start presented during the done cycle is accepted immediately.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        steps_left_d = steps_left_q;
        rot_a_d      = rot_a_q;
        rot_b_d      = rot_b_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        timer_load   = 1'b0;
        timer_value  = PH_LOAD;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (steps != '0) begin
                        state_d              = ST_PH1;
                        dir_d                = dir;
                        steps_left_d         = steps;
                        busy_d               = 1'b1;
                        {rot_a_d, rot_b_d}   = phase_ab(ST_PH1, dir);
                        timer_load           = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_PH1, ST_PH2, ST_PH3: begin
                if (timer_expired) begin
                    state_d            = (state_q == ST_PH1) ? ST_PH2 :
                                         (state_q == ST_PH2) ? ST_PH3 : ST_PH0;
                    {rot_a_d, rot_b_d} = phase_ab(state_d, dir_q);
                    timer_load         = 1'b1;
                end
            end
            ST_PH0: begin
                if (timer_expired) begin
                    steps_left_d = steps_left_q - 1'b1;
                    if (steps_left_q == {{(STEP_W-1){1'b0}}, 1'b1}) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (DWELL_CYC > 0) begin
                        state_d     = ST_DWELL;
                        timer_load  = 1'b1;
                        timer_value = DW_LOAD;
                    end else begin
                        state_d            = ST_PH1;
                        {rot_a_d, rot_b_d} = phase_ab(ST_PH1, dir_q);
                        timer_load         = 1'b1;
                    end
                end
            end
            ST_DWELL: begin
                if (timer_expired) begin
                    state_d            = ST_PH1;
                    {rot_a_d, rot_b_d} = phase_ab(ST_PH1, dir_q);
                    timer_load         = 1'b1;
                end
            end
            default: begin
                state_d            = ST_IDLE;
                busy_d             = 1'b0;
                {rot_a_d, rot_b_d} = AB_DETENT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dir_q        <= 1'b0;
            steps_left_q <= '0;
            rot_a_q      <= 1'b0;
            rot_b_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            steps_left_q <= steps_left_d;
            rot_a_q      <= rot_a_d;
            rot_b_q      <= rot_b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign ROT_A      = rot_a_q;
    assign ROT_B      = rot_b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign steps_left = steps_left_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench for quad_encoder_gen: table-driven sequences, random
// sequences and hand-written corner cases against a per-cycle waveform model.
module tb_quad_encoder_gen;

    localparam int P  = 4;
    localparam int D  = 8;
    localparam int SW = 8;
    localparam int EW = SW + 4;

    logic          clk;
    logic          reset;
    logic          start;
    logic          dir;
    logic [SW-1:0] steps;
    logic          rot_a;
    logic          rot_b;
    logic          busy;
    logic          done;
    logic [SW-1:0] steps_left;

    quad_encoder_gen #(.PHASE_CYC(P), .DWELL_CYC(D), .STEP_W(SW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dir        (dir),
        .steps      (steps),
        .ROT_A      (rot_a),
        .ROT_B      (rot_b),
        .busy       (busy),
        .done       (done),
        .steps_left (steps_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [EW-1:0] exp_q[$];
    logic [1:0]    pat[2][4];

    typedef struct {
        logic dir;
        int   steps;
        int   interfere_at;
        int   exp_busy;
    } vec_t;
    vec_t vecs[5];

    function automatic logic [EW-1:0] pack(input logic a, input logic b, input logic bsy,
                                           input logic dn, input int left);
        return {a, b, bsy, dn, SW'(left)};
    endfunction

    function automatic logic [EW-1:0] observed();
        return {rot_a, rot_b, busy, done, steps_left};
    endfunction

    task automatic check_vec(input string name, input int idx, input logic [EW-1:0] exp);
        logic [EW-1:0] got;
        got = observed();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s idx=%0d got {A,B,busy,done,left}=%b_%b_%b_%b_%0d expected %b_%b_%b_%b_%0d",
                     name, idx, got[SW+3], got[SW+2], got[SW+1], got[SW], got[SW-1:0],
                     exp[SW+3], exp[SW+2], exp[SW+1], exp[SW], exp[SW-1:0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Waveform of a whole sequence, one entry per cycle after the accepting edge.
    task automatic build_expected(input logic d, input int n);
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            for (int ph = 0; ph < 4; ph++) begin
                for (int c = 0; c < P; c++) begin
                    exp_q.push_back(pack(pat[d][ph][1], pat[d][ph][0], 1'b1, 1'b0, n - k));
                end
            end
            if (k < n - 1) begin
                for (int c = 0; c < D; c++) begin
                    exp_q.push_back(pack(1'b0, 1'b0, 1'b1, 1'b0, n - k - 1));
                end
            end
        end
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b1, 0));
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 0));
    endtask

    task automatic launch(input logic d, input int n);
        start = 1'b1;
        dir   = d;
        steps = SW'(n);
    endtask

    // Caller has set start; the first edge here accepts it.
    task automatic check_seq(input string name, input logic d, input int n, input int interfere_at,
                             input logic chain, input logic chain_dir, input int chain_n);
        logic [EW-1:0] e;
        int idx;
        int busy_seen;
        build_expected(d, n);
        idx       = 0;
        busy_seen = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clk);
            #1;
            start = 1'b0;
            dir   = 1'($urandom_range(0, 1));
            steps = SW'($urandom_range(0, 255));
            check_vec(name, idx, e);
            if (busy) busy_seen++;
            if (idx == interfere_at) begin
                start = 1'b1;
                dir   = ~d;
                steps = SW'(n + 3);
            end
            if (chain && e[SW]) begin
                start = 1'b1;
                dir   = chain_dir;
                steps = SW'(chain_n);
                break;
            end
            idx++;
        end
        check_int({name, "_busy_cycles"}, busy_seen, n * 4 * P + (n - 1) * D);
    endtask

    initial begin
        pat[1] = '{2'b10, 2'b11, 2'b01, 2'b00};
        pat[0] = '{2'b01, 2'b11, 2'b10, 2'b00};

        vecs[0] = '{dir: 1'b1, steps: 1,   interfere_at: -1, exp_busy: 16};
        vecs[1] = '{dir: 1'b0, steps: 2,   interfere_at: -1, exp_busy: 40};
        vecs[2] = '{dir: 1'b1, steps: 3,   interfere_at: 30, exp_busy: 64};
        vecs[3] = '{dir: 1'b0, steps: 2,   interfere_at: 0,  exp_busy: 40};
        vecs[4] = '{dir: 1'b1, steps: 255, interfere_at: 39, exp_busy: 6112};

        reset = 1'b1;
        start = 1'b0;
        dir   = 1'b0;
        steps = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_vec("reset", 0, pack(1'b0, 1'b0, 1'b0, 1'b0, 0));
        @(posedge clk);
        #1;
        check_vec("post_reset_idle", 0, pack(1'b0, 1'b0, 1'b0, 1'b0, 0));

        for (int i = 0; i < 5; i++) begin
            launch(vecs[i].dir, vecs[i].steps);
            check_seq($sformatf("vec%0d", i), vecs[i].dir, vecs[i].steps,
                      vecs[i].interfere_at, 1'b0, 1'b0, 0);
            check_int($sformatf("vec%0d_table_busy", i),
                      vecs[i].steps * 4 * P + (vecs[i].steps - 1) * D, vecs[i].exp_busy);
        end

        // steps=0: done next cycle, busy and AB stay low
        launch(1'b1, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_vec("zero_steps_done", 0, pack(1'b0, 1'b0, 1'b0, 1'b1, 0));
        for (int i = 1; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_vec("zero_steps_idle", i, pack(1'b0, 1'b0, 1'b0, 1'b0, 0));
        end

        // start presented on the done cycle is accepted back-to-back
        launch(1'b1, 1);
        check_seq("chain_a", 1'b1, 1, -1, 1'b1, 1'b0, 2);
        check_seq("chain_b", 1'b0, 2, -1, 1'b0, 1'b0, 0);

        // reset during PH2 abandons the sequence without a done pulse
        launch(1'b1, 3);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check_vec("pre_reset_ph2", 5, pack(1'b1, 1'b1, 1'b1, 1'b0, 3));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_vec("mid_reset", 0, pack(1'b0, 1'b0, 1'b0, 1'b0, 0));
        for (int i = 1; i < 20; i++) begin
            @(posedge clk);
            #1;
            check_vec("after_mid_reset", i, pack(1'b0, 1'b0, 1'b0, 1'b0, 0));
        end

        // random sequences
        for (int r = 0; r < 8; r++) begin
            logic rd;
            int   rn;
            int   ri;
            rd = 1'($urandom_range(0, 1));
            rn = $urandom_range(1, 5);
            ri = ($urandom_range(0, 1) == 1) ? $urandom_range(0, rn * 4 * P + (rn - 1) * D - 1) : -1;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            launch(rd, rn);
            check_seq($sformatf("rand%0d", r), rd, rn, ri, 1'b0, 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
